fsm_div: RTL and testbench

//  Serial-input arithmetic FSM. Computes res = a / b - c - d on signed 4-bit operands.
//  The four operands arrive one per valid_in strobe on a shared 4-bit bus.

---
 rtl/fsm_div.sv | 154 +++++++++++++++
 tb/tb_fsm_div.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fsm_div.sv
// fsm_div: serial-input signed arithmetic unit computing a / b - c - d.
// Operands a, b, c, d arrive one per valid_in strobe on a shared bus.
// The division is a W-cycle restoring divide on magnitudes, followed by a
// sign fix and two wrap-around subtractions. The result and error flag are
// registered and held until the next completion strobe or reset.
module fsm_div #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [W-1:0] d_in,
  output logic         valid_out,
  output logic [W-1:0] d_out,
  output logic         error_out
);

  localparam int CW = $clog2(W);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    GET_B = 4'd1,
    GET_C = 4'd2,
    GET_D = 4'd3,
    DIV   = 4'd4,
    FIX   = 4'd5,
    SUB_C = 4'd6,
    SUB_D = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t state, state_d;

  logic [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [W-1:0]  dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          erro_q, erro_d;

  logic [W:0]    rem_sh;
  logic [W:0]    diff;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  // State and datapath registers; reset has priority in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      erro_q  <= 1'b0;
    end else begin
      state   <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      erro_q  <= erro_d;
    end
  end

  // Next-state and datapath logic: operand capture, divide, fix, subtract, report.
  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    err_d   = err_q;
    valid_d = 1'b0;
    dout_d  = dout_q;
    erro_d  = erro_q;

    // Restoring step: borrow out of the trial subtraction means "does not fit".
    rem_sh = {rem_q, dvd_q[W-1]};
    diff   = rem_sh - {1'b0, mag(b_q)};

    case (state)
      IDLE: if (valid_in) begin
        a_d     = d_in;
        state_d = GET_B;
      end
      GET_B: if (valid_in) begin
        b_d     = d_in;
        state_d = GET_C;
      end
      GET_C: if (valid_in) begin
        c_d     = d_in;
        state_d = GET_D;
      end
      GET_D: if (valid_in) begin
        d_d     = d_in;
        err_d   = (a_q == '0) || (b_q == '0);
        dvd_d   = mag(a_q);
        rem_d   = '0;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        rem_d = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
        dvd_d = {dvd_q[W-2:0], ~diff[W]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = FIX;
      end
      FIX: begin
        q_d     = (a_q[W-1] ^ b_q[W-1]) ? -dvd_q : dvd_q;
        state_d = SUB_C;
      end
      SUB_C: begin
        q_d     = q_q - c_q;
        state_d = SUB_D;
      end
      SUB_D: begin
        dout_d  = err_q ? '0 : (q_q - d_q);
        erro_d  = err_q;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign valid_out = valid_q;
  assign d_out     = dout_q;
  assign error_out = erro_q;

endmodule

// File: tb/tb_fsm_div.sv
// tb_fsm_div: directed cases with literal expectations plus a free-running
// random stream, all checked every cycle against a transaction-level model.
module tb_fsm_div;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [3:0] d_in = '0;
  logic       valid_out;
  logic [3:0] d_out;
  logic       error_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e0 = 0;

  fsm_div #(.W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .d_in     (d_in),
    .valid_out(valid_out),
    .d_out    (d_out),
    .error_out(error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: operands gathered in order; result = trunc(a/b) - c - d mod 16,
  // reported 7 edges after d is taken, busy until one edge past the strobe.
  logic [3:0] ops[4];
  int         nops = 0;
  bit         busy = 0;
  int         done_at = 0;
  logic [3:0] res_m;
  bit         err_m;
  bit         exp_valid = 0;
  logic [3:0] exp_dout = '0;
  bit         exp_err = 0;

  function automatic logic [3:0] model(input logic [3:0] a, b, c, d, output bit err);
    int sa, sb, sc, sd, q;
    sa = int'($signed(a)); sb = int'($signed(b));
    sc = int'($signed(c)); sd = int'($signed(d));
    err = (sa == 0) || (sb == 0);
    if (err) return 4'd0;
    q = sa / sb;
    return 4'(q - sc - sd);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      nops = 0; busy = 0;
      exp_valid = 0; exp_dout = '0; exp_err = 0;
    end else begin
      exp_valid = 0;
      if (busy && cyc == done_at) begin
        exp_valid = 1; exp_dout = res_m; exp_err = err_m;
      end
      if (busy && cyc == done_at + 1) begin
        busy = 0;
      end else if (!busy && valid_in) begin
        ops[nops] = d_in;
        nops++;
        if (nops == 4) begin
          res_m   = model(ops[0], ops[1], ops[2], ops[3], err_m);
          done_at = cyc + 7;
          busy    = 1;
          nops    = 0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("valid_out", int'(valid_out), int'(exp_valid));
      chk("d_out", int'(d_out), int'(exp_dout));
      chk("error_out", int'(error_out), int'(exp_err));
    end
  end

  task automatic send(input logic [3:0] a, b, c, d, input int unsigned gap);
    logic [3:0] o[4];
    o = '{a, b, c, d};
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      d_in = o[i];
      if (i < 3) begin
        for (int unsigned k = 0; k < gap; k++) begin
          @(negedge clk);
          valid_in = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic [3:0] a, b, c, d,
                         input int unsigned gap, input bit xerr, input logic [3:0] xdout);
    int waited;
    send(a, b, c, d, gap);
    waited = 0;
    while (!valid_out && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!valid_out) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_latency"}, cyc - e0, 7);
      chk({name, "_err"}, int'(error_out), int'(xerr));
      chk({name, "_dout"}, int'(d_out), int'(xdout));
      @(negedge clk);
      chk({name, "_pulse"}, int'(valid_out), 0);
      chk({name, "_hold"}, int'(d_out), int'(xdout));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", int'(dut.state), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_dout", int'(d_out), 0);
    reset = 1'b0;

    run_txn("t1_b0",   4'd5,  4'd0, 4'd1, 4'd2, 1, 1'b1, 4'd0);
    run_txn("t2_a0",   4'd0,  4'd4, 4'd3, 4'd2, 0, 1'b1, 4'd0);
    run_txn("t3_ab0",  4'd0,  4'd0, 4'd1, 4'd2, 1, 1'b1, 4'd0);
    run_txn("t4_wrap", 4'd8,  4'd2, 4'd5, 4'd2, 0, 1'b0, 4'b0101);
    run_txn("t4_neg",  4'd6,  4'd2, 4'd5, 4'd2, 1, 1'b0, 4'b1100);
    run_txn("ovf",     4'd8,  4'hF, 4'd0, 4'd0, 0, 1'b0, 4'b1000);
    run_txn("t5_trunc",4'h9,  4'd2, 4'd1, 4'd3, 1, 1'b0, 4'b1001);

    // Reset while dividing; previous result (nonzero) must be cleared.
    send(4'd7, 4'd3, 4'd1, 4'd1, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("middiv_state", int'(dut.state), 0);
    chk("middiv_valid", int'(valid_out), 0);
    chk("middiv_dout", int'(d_out), 0);
    chk("middiv_err", int'(error_out), 0);
    run_txn("after_rst", 4'd6, 4'd2, 4'd5, 4'd2, 1, 1'b0, 4'b1100);

    // Free-running random stream including strobes while busy and rare resets.
    for (int unsigned i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 299) == 0);
      valid_in = ($urandom_range(0, 2) != 0);
      d_in     = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    valid_in = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
